// File: rtl/prefetch_pkg.sv
// Purpose: shared types and constants for the instruction prefetch unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: fetch FSM state enum, datapath width, PC increment, FIFO entry struct.
package prefetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_WAIT,
        PF_DISCARD
    } pf_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } pf_entry_t;

endpackage

// File: rtl/pf_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO of pf_entry_t.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: caller must not push while full unless it also pops; flush beats push.
//
// Ports: clk, reset (sync, active-high), push/wdata, pop, flush,
//        full, empty, count (entries held), head (zero when empty).
module pf_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  pf_entry_t                wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output pf_entry_t                head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pf_entry_t         mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              do_pop;

    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    assign count  = cnt;
    assign do_pop = pop & ~empty;
    assign head   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Purpose: sequential instruction prefetch, one outstanding memory request, FWFT buffer to the core.
// Latency: redirect at N -> mem_req at N+1 -> rvalid at N+2 (zero-wait) -> instr_valid at N+3.
// Backpressure: core stalls via instr_ready=0; requests stop once held + outstanding reaches DEPTH.
//
// Ports: clk, reset (sync, active-high); memory side mem_req/mem_addr/mem_gnt,
//        mem_rvalid/mem_rdata; redirect/redirect_pc from Execute; core side
//        instr_valid/instr/instr_pc/instr_ready.
// Optional: define PREFETCH_PERF_EN to add perf_flush_cnt (redirect cycles) and
//        perf_drop_cnt (discarded responses), both saturating.
module instr_prefetch
    import prefetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_drop_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_t        state;
    pf_state_t        state_nxt;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  target_pc;
    logic             grant;
    logic             rsp_push;
    logic             rsp_drop;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    pf_entry_t        fifo_wdata;
    pf_entry_t        fifo_head;

    assign target_pc = redirect_pc & ~XLEN'(3);
    assign mem_addr  = fetch_pc;
    assign grant     = mem_req & mem_gnt;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        rsp_push  = 1'b0;
        rsp_drop  = 1'b0;
        case (state)
            PF_IDLE: begin
                // Only issued from IDLE, so the outstanding slot is free and the
                // FIFO occupancy alone decides whether the response will fit.
                mem_req = ~reset & ~redirect & (fifo_count < CW'(DEPTH));
                if (mem_req && mem_gnt) begin
                    state_nxt = PF_WAIT;
                end
            end
            PF_WAIT: begin
                if (mem_rvalid) begin
                    rsp_push  = ~redirect;
                    rsp_drop  = redirect;
                    state_nxt = PF_IDLE;
                end else if (redirect) begin
                    state_nxt = PF_DISCARD;
                end
            end
            PF_DISCARD: begin
                if (mem_rvalid) begin
                    rsp_drop  = 1'b1;
                    state_nxt = PF_IDLE;
                end
            end
            default: begin
                state_nxt = PF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PF_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= target_pc;
            end else if (grant) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (grant) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // A same-cycle pop frees the slot, so push-while-full is legal then.
    assign fifo_pop         = instr_valid & instr_ready;
    assign fifo_push        = rsp_push & (~fifo_full | fifo_pop);
    assign fifo_wdata.instr = mem_rdata;
    assign fifo_wdata.pc    = req_pc;

    pf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (redirect),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_flush_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (redirect && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (rsp_drop && perf_drop_cnt != '1) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
